// File: rtl/servo_pkg.sv
// Shared defaults and FSM state encoding for the servo pulse reader and pulse generator.
package servo_pkg;

    localparam int unsigned SERVO_CLK_DIV       = 196;
    localparam int unsigned SERVO_MIN_TICKS     = 255;
    localparam int unsigned SERVO_MAX_TICKS     = 1024;
    localparam int unsigned SERVO_GLITCH_TICKS  = 16;
    localparam int unsigned SERVO_TIMEOUT_TICKS = 6400;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2
    } servo_state_t;

endpackage

// File: rtl/servo_tick_gen.sv
// Measurement tick prescaler: one-cycle tick every CLK_DIV clocks, phase realigned by restart.
module servo_tick_gen
    import servo_pkg::*;
#(
    parameter int unsigned CLK_DIV = SERVO_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart || tick) cnt <= '0;
        else                        cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/servo_pulse_reader.sv
// Servo PWM reader: measures the high time in prescaled ticks and maps it to an 8-bit position.
// Build macro SERVO_RD_AVG_EN averages the last four positions and adds one cycle of latency.
module servo_pulse_reader
    import servo_pkg::*;
#(
    parameter int unsigned CLK_DIV       = SERVO_CLK_DIV,
    parameter int unsigned MIN_TICKS     = SERVO_MIN_TICKS,
    parameter int unsigned MAX_TICKS     = SERVO_MAX_TICKS,
    parameter int unsigned GLITCH_TICKS  = SERVO_GLITCH_TICKS,
    parameter int unsigned TIMEOUT_TICKS = SERVO_TIMEOUT_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena_in,
    input  logic       pulse_in,
    output logic [7:0] position,
    output logic       pos_valid,
    output logic       signal_ok,
    output logic       err_long
);

    localparam int unsigned HCNT_W = $clog2(MAX_TICKS + 2);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [HCNT_W-1:0] HCNT_SAT = HCNT_W'(MAX_TICKS + 1);
    localparam logic [HCNT_W-1:0] GLITCH_W = HCNT_W'(GLITCH_TICKS);
    localparam logic [HCNT_W:0]   MIN_EXT  = (HCNT_W + 1)'(MIN_TICKS);
    localparam logic [HCNT_W:0]   POS_TOP  = (HCNT_W + 1)'(255);
    localparam logic [TCNT_W-1:0] TCNT_SAT = TCNT_W'(TIMEOUT_TICKS);

    function automatic logic [7:0] clamp_pos(input logic [HCNT_W-1:0] w);
        logic [HCNT_W:0] diff;
        diff = {1'b0, w} - MIN_EXT;
        if (diff[HCNT_W])        clamp_pos = 8'd0;
        else if (diff > POS_TOP) clamp_pos = 8'hff;
        else                     clamp_pos = diff[7:0];
    endfunction

    logic              sync_a, sync_b, line_d;
    logic [1:0]        sync_fill;
    logic              rise, fall, sync_ready, tick, expire;
    logic [HCNT_W-1:0] hcnt;
    logic [TCNT_W-1:0] tcnt;
    servo_state_t      state, state_nx;
    logic              cap_vld, cap_err;
    logic              vld_p0, err_p0;
    logic [HCNT_W-1:0] width_p0;
    logic              out_vld, out_err;
    logic [7:0]        out_pos;

    // sync_fill marks when sync_b reflects the pin again after reset, so a pulse
    // already high at reset release is not mistaken for a fresh rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            line_d    <= 1'b0;
            sync_fill <= 2'b00;
        end else begin
            sync_a    <= pulse_in;
            sync_b    <= sync_a;
            line_d    <= sync_b;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign rise       = sync_b & ~line_d;
    assign fall       = ~sync_b & line_d;
    assign sync_ready = sync_fill[1];

    servo_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (rise | ~ena_in),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst || !ena_in || rise)                        hcnt <= '0;
        else if (state == HIGH && tick && hcnt != HCNT_SAT) hcnt <= hcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || !ena_in || rise)       tcnt <= '0;
        else if (tick && tcnt != TCNT_SAT) tcnt <= tcnt + 1'b1;
    end

    // a rising edge in the same cycle wins over expiry
    assign expire = (tcnt == TCNT_SAT) && !rise;

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_LOW;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cap_vld  = 1'b0;
        cap_err  = 1'b0;
        if (!ena_in) begin
            state_nx = WAIT_LOW;
        end else begin
            case (state)
                WAIT_LOW: if (sync_ready && !sync_b) state_nx = IDLE;
                IDLE:     if (rise) state_nx = HIGH;
                HIGH: begin
                    if (hcnt == HCNT_SAT) begin
                        state_nx = WAIT_LOW;
                        cap_err  = 1'b1;
                    end else if (fall) begin
                        state_nx = IDLE;
                        cap_vld  = (hcnt >= GLITCH_W);
                    end
                end
                default: state_nx = WAIT_LOW;
            endcase
        end
    end

    // Stage p0: capture width and strobes at the end of the pulse
    always_ff @(posedge clk) begin
        if (rst || !ena_in) begin
            vld_p0 <= 1'b0;
            err_p0 <= 1'b0;
        end else begin
            vld_p0 <= cap_vld;
            err_p0 <= cap_err;
        end
    end

    always_ff @(posedge clk) begin
        width_p0 <= hcnt;
    end

`ifdef SERVO_RD_AVG_EN
    function automatic logic [7:0] avg4(input logic [3:0][7:0] h);
        logic [9:0] sum;
        sum  = 10'(h[0]) + 10'(h[1]) + 10'(h[2]) + 10'(h[3]);
        avg4 = sum[9:2];
    endfunction

    logic [3:0][7:0] hist_p1;
    logic            hist_fill, vld_p1, err_p1;

    // Stage p1: clamp and push into the history; refill after reset or signal loss
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_p1   <= '0;
            hist_fill <= 1'b1;
            vld_p1    <= 1'b0;
            err_p1    <= 1'b0;
        end else begin
            vld_p1 <= vld_p0 && ena_in;
            err_p1 <= err_p0 && ena_in;
            if (!ena_in || expire) begin
                hist_fill <= 1'b1;
            end else if (vld_p0) begin
                hist_fill <= 1'b0;
                if (hist_fill) hist_p1 <= {4{clamp_pos(width_p0)}};
                else           hist_p1 <= {hist_p1[2:0], clamp_pos(width_p0)};
            end
        end
    end

    assign out_vld = vld_p1;
    assign out_err = err_p1;
    assign out_pos = avg4(hist_p1);
`else
    assign out_vld = vld_p0;
    assign out_err = err_p0;
    assign out_pos = clamp_pos(width_p0);
`endif

    // Output stage: registered strobes, held position, signal presence level
    always_ff @(posedge clk) begin
        if (rst) begin
            position  <= 8'd0;
            pos_valid <= 1'b0;
            err_long  <= 1'b0;
            signal_ok <= 1'b0;
        end else if (!ena_in) begin
            pos_valid <= 1'b0;
            err_long  <= 1'b0;
            signal_ok <= 1'b0;
        end else begin
            pos_valid <= out_vld;
            err_long  <= out_err;
            if (out_vld) begin
                position  <= out_pos;
                signal_ok <= 1'b1;
            end else if (expire) begin
                signal_ok <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_servo_pulse_reader.sv
// Directed bench for servo_pulse_reader with a 2-clock tick; pulse widths given directly in ticks.
module tb_servo_pulse_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena_in;
    logic       pulse_in;
    logic [7:0] position;
    logic       pos_valid;
    logic       signal_ok;
    logic       err_long;

    int checks   = 0;
    int errors   = 0;
    int vld_seen = 0;
    int err_seen = 0;
    int v0;
    int e0;

`ifdef SERVO_RD_AVG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    servo_pulse_reader #(
        .CLK_DIV (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena_in    (ena_in),
        .pulse_in  (pulse_in),
        .position  (position),
        .pos_valid (pos_valid),
        .signal_ok (signal_ok),
        .err_long  (err_long)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pos_valid) vld_seen <= vld_seen + 1;
        if (err_long)  err_seen <= err_seen + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // High for 2*w+1 clocks gives exactly w completed ticks with CLK_DIV=2
    task automatic send_pulse(input int w, input string tag, input int exp_lat, input int exp_pos);
        int lat;
        int vb;
        vb = vld_seen;
        @(posedge clk); #1 pulse_in = 1'b1;
        repeat (2 * w + 1) @(posedge clk);
        #1 pulse_in = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (pos_valid && lat == 0) lat = i;
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_pos"}, position, exp_pos);
        check_eq({tag, "_cnt"}, vld_seen - vb, (exp_lat == 0) ? 0 : 1);
        repeat (20) @(posedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        ena_in   = 1'b1;
        pulse_in = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_eq("rst_pos", position, 0);
        check_eq("rst_vld", pos_valid, 0);
        check_eq("rst_sok", signal_ok, 0);
        check_eq("rst_err", err_long, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

`ifdef SERVO_RD_AVG_EN
        send_pulse(355, "avg1", LAT, 100);
        send_pulse(355, "avg2", LAT, 100);
        send_pulse(355, "avg3", LAT, 100);
        send_pulse(455, "avg4", LAT, 125);
        check_eq("avg_sok", signal_ok, 1);
`else
        send_pulse(382, "p1500", LAT, 127);
        check_eq("p1500_sok", signal_ok, 1);
        send_pulse(255, "p1000", LAT, 0);
        send_pulse(204, "p800", LAT, 0);
        send_pulse(510, "p2000", LAT, 255);
        send_pulse(637, "p2500", LAT, 255);
        send_pulse(16, "glitch_edge", LAT, 0);
        send_pulse(382, "p1500b", LAT, 127);
        send_pulse(2, "glitch10us", 0, 127);
        send_pulse(15, "glitch15", 0, 127);

        e0 = err_seen;
        send_pulse(1275, "p5ms", 0, 127);
        check_eq("p5ms_err", err_seen - e0, 1);
        send_pulse(306, "p1200", LAT, 51);

        e0 = err_seen;
        send_pulse(1024, "max_ok", LAT, 255);
        check_eq("max_ok_err", err_seen - e0, 0);
        e0 = err_seen;
        send_pulse(1025, "max_over", 0, 255);
        check_eq("max_over_err", err_seen - e0, 1);

        // send_pulse consumes 2*w+1+28 clocks from its rising edge
        send_pulse(382, "pre_to", LAT, 127);
        repeat (12800 - (2 * 382 + 1) - 28) @(posedge clk); #1;
        check_eq("to_before", signal_ok, 1);
        repeat (8) @(posedge clk); #1;
        check_eq("to_after", signal_ok, 0);
        check_eq("to_pos", position, 127);

        v0 = vld_seen;
        @(posedge clk); #1 pulse_in = 1'b1;
        repeat (200) @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk); #1 rst = 1'b0;
        repeat (800) @(posedge clk); #1 pulse_in = 1'b0;
        repeat (10) @(posedge clk); #1;
        check_eq("rstmid_cnt", vld_seen - v0, 0);
        check_eq("rstmid_pos", position, 0);
        check_eq("rstmid_sok", signal_ok, 0);
        repeat (10) @(posedge clk);
        send_pulse(382, "resume", LAT, 127);

        @(posedge clk); #1 ena_in = 1'b0;
        repeat (2) @(posedge clk); #1;
        check_eq("ena_off_sok", signal_ok, 0);
        send_pulse(510, "ena_off", 0, 127);
        @(posedge clk); #1 ena_in = 1'b1;
        repeat (5) @(posedge clk);
        send_pulse(306, "ena_on", LAT, 51);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servo_pulse_reader.md
SERVO_PULSE_READER -- requirements
Module: servo_pulse_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 196: clk cycles per measurement tick (about 3.92 us at 50 MHz).
REQ-002 SHALL have parameter MIN_TICKS, default 255: pulse width in ticks that maps to position 0 (about 1000 us).
REQ-003 SHALL have parameter MAX_TICKS, default 1024: widths above this are errors.
REQ-004 SHALL have parameter GLITCH_TICKS, default 16: pulses shorter than this are ignored.
REQ-005 SHALL have parameter TIMEOUT_TICKS, default 6400: ticks without a rising edge before signal loss (about 25 ms).
REQ-006 SHALL have port clk, input, 1 bit: the single clock (FPGA_CLK1_50 domain).
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port ena_in, input, 1 bit: enable for the measurement engine.
REQ-009 SHALL have port pulse_in, input, 1 bit: asynchronous servo PWM from a GPIO pin.
REQ-010 SHALL have port position, output, 8 bits: last decoded position, held between updates.
REQ-011 SHALL have port pos_valid, output, 1 bit: one-cycle strobe when position updates.
REQ-012 SHALL have port signal_ok, output, 1 bit: level, high while valid pulses arrive.
REQ-013 SHALL have port err_long, output, 1 bit: one-cycle strobe on an over-long pulse.

Function
REQ-014 SHALL pass pulse_in through a 2-flop synchronizer, then register it once for edge detection.
REQ-015 SHALL implement states WAIT_LOW, IDLE and HIGH.
- WAIT_LOW -> IDLE when the synchronized line is low.
- IDLE -> HIGH on a rising edge.
- HIGH -> IDLE on a falling edge.
- HIGH -> WAIT_LOW when the tick count exceeds MAX_TICKS.
REQ-016 SHALL restart the tick prescaler on every rising edge; the high counter increments once per completed tick while in HIGH.
REQ-017 SHALL saturate the high counter at MAX_TICKS+1 (11 bits).
REQ-018 SHALL, on a falling edge with width W below GLITCH_TICKS, discard the pulse: no strobe, outputs unchanged.
REQ-019 SHALL, on a falling edge with W at or above GLITCH_TICKS, compute position = clamp(W - MIN_TICKS, 0, 255).
REQ-020 SHALL, for a valid pulse, strobe pos_valid and set signal_ok.
REQ-021 SHALL assert pos_valid exactly 4 clk cycles after pulse_in falls (2 sync + 1 edge + 1 output register).
REQ-022 SHALL, on an over-long pulse (W above MAX_TICKS), pulse err_long once, leave position unchanged, and go to WAIT_LOW.
REQ-023 SHALL count ticks since the last rising edge, saturating; when the count reaches TIMEOUT_TICKS, clear signal_ok and hold position.
REQ-024 SHALL give a rising edge priority over timeout expiry when both occur in the same cycle: the counter clears and signal_ok is not cleared.
REQ-025 SHALL, while ena_in is low, force WAIT_LOW, clear counters, hold pos_valid, err_long and signal_ok at 0, and hold position.

Reset
REQ-026 SHALL, on rst, set position=0, pos_valid=0, signal_ok=0, err_long=0 and state=WAIT_LOW, and clear the synchronizer and all counters.
REQ-027 SHALL discard any pulse in progress when reset is applied mid-pulse; measurement resumes only after the line is seen low.

Configuration
REQ-028 SHALL support macro SERVO_RD_AVG_EN.
- Defined: position = (sum of the last 4 clamped values) >> 2.
- Defined: the history is cleared by reset; the first valid value after reset or a signal loss fills all 4 entries.
- Defined: pos_valid latency becomes 5 cycles.
- Undefined: position is the single latest value, as in REQ-019.

Structure
REQ-029 SHALL keep in shared package servo_pkg the defaults for CLK_DIV, MIN_TICKS, MAX_TICKS, GLITCH_TICKS and TIMEOUT_TICKS, plus the state enum; the pulse-generator side uses the same CLK_DIV and MIN_TICKS.
REQ-030 SHALL implement the tick prescaler as sub-module servo_tick_gen, with inputs clk, rst and restart and a one-cycle tick output.

Verification
REQ-031 SHALL cover: 1500 us pulse (75000 cycles) -> W=382, position=127, pos_valid exactly 4 cycles after the falling edge, signal_ok=1.
REQ-032 SHALL cover: 1000 us -> position=0; 800 us -> position=0 (clamped); 2000 us -> 255; 2500 us -> 255 (clamped).
REQ-033 SHALL cover: 10 us glitch after a valid 1500 us pulse -> no pos_valid, position stays 127.
REQ-034 SHALL cover: 5 ms pulse -> one err_long strobe, position unchanged, next 1200 us pulse gives position=51.
REQ-035 SHALL cover: valid pulses, then line held low for 30 ms -> signal_ok falls 6400 ticks after the last rising edge; rst asserted mid-pulse -> no strobe for that pulse.
REQ-036 SHALL cover, with SERVO_RD_AVG_EN defined: pulses giving values 100,100,100,200 after reset -> position sequence 100,100,100,125.
